// File: rtl/store_axi_writer.sv
// Store-side AXI3 writer: formats one sb/sh/sw store into a single-beat write
// and stalls the pipeline until the B response returns. req_op = {sb, sh, sw}.
module store_axi_writer #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        req_ready,
  output logic        stall_req,
  output logic        done,
  output logic        bus_err,
  output logic        addr_err,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  logic        aw_done_r;
  logic        w_done_r;
  logic        awvalid_r;
  logic        wvalid_r;
  logic        bready_r;
  logic        done_r;
  logic        bus_err_r;
  logic        addr_err_r;
  logic        stall_r;
  logic        req_ready_r;
  logic [31:0] awaddr_r;
  logic [2:0]  awsize_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;

  logic        sel_sw_s;
  logic        sel_sh_s;
  logic        sel_sb_s;
  logic        accept_s;
  logic        misalign_s;
  logic        aw_hs_s;
  logic        w_hs_s;
  logic        aw_fin_s;
  logic        w_fin_s;
  logic        b_hs_s;
  logic        unused_s;

  // Byte-lane strobe for the selected access width and address offset.
  function automatic logic [3:0] strobe_for(input logic sb, input logic sh,
                                            input logic [1:0] a);
    logic [3:0] s;
    if (sb) begin
      s = 4'b0001 << a;
    end else if (sh) begin
      s = a[1] ? 4'b1100 : 4'b0011;
    end else begin
      s = 4'b1111;
    end
    return s;
  endfunction

  // Replicate the store value across all lanes so any strobe picks correct bytes.
  function automatic logic [31:0] data_for(input logic sb, input logic sh,
                                           input logic [31:0] d);
    logic [31:0] r;
    if (sb) begin
      r = {4{d[7:0]}};
    end else if (sh) begin
      r = {2{d[15:0]}};
    end else begin
      r = d;
    end
    return r;
  endfunction

  // AXI size encoding: 1, 2 or 4 bytes.
  function automatic logic [2:0] size_for(input logic sb, input logic sh);
    logic [2:0] z;
    if (sb) begin
      z = 3'd0;
    end else if (sh) begin
      z = 3'd1;
    end else begin
      z = 3'd2;
    end
    return z;
  endfunction

  // Decode request with sw > sh > sb priority and classify alignment.
  always_comb begin
    sel_sw_s   = req_op[0];
    sel_sh_s   = req_op[1] & ~req_op[0];
    sel_sb_s   = req_op[2] & ~req_op[1] & ~req_op[0];
    accept_s   = (state_r == IDLE) && req_valid && (req_op != 3'b000);
    misalign_s = (sel_sw_s && (req_addr[1:0] != 2'b00)) ||
                 (sel_sh_s && req_addr[0]);
  end

  // Channel handshakes; a finished channel counts its same-cycle handshake.
  always_comb begin
    aw_hs_s  = awvalid_r && awready;
    w_hs_s   = wvalid_r && wready;
    aw_fin_s = aw_done_r || aw_hs_s;
    w_fin_s  = w_done_r || w_hs_s;
    b_hs_s   = bready_r && bvalid;
  end

  // Main controller: state, channel valids, payload registers and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      done_r      <= 1'b0;
      bus_err_r   <= 1'b0;
      addr_err_r  <= 1'b0;
      stall_r     <= 1'b0;
      req_ready_r <= 1'b1;
      awaddr_r    <= 32'd0;
      awsize_r    <= 3'd0;
      wdata_r     <= 32'd0;
      wstrb_r     <= 4'd0;
    end else begin
      done_r     <= 1'b0;
      bus_err_r  <= 1'b0;
      addr_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          stall_r     <= accept_s && !misalign_s;
          req_ready_r <= !(accept_s && !misalign_s);
          if (accept_s) begin
            if (misalign_s) begin
              addr_err_r <= 1'b1;
            end else begin
              awaddr_r  <= req_addr;
              awsize_r  <= size_for(sel_sb_s, sel_sh_s);
              wdata_r   <= data_for(sel_sb_s, sel_sh_s, req_data);
              wstrb_r   <= strobe_for(sel_sb_s, sel_sh_s, req_addr[1:0]);
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              aw_done_r <= 1'b0;
              w_done_r  <= 1'b0;
              state_r   <= SEND;
            end
          end
        end
        SEND: begin
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b1;
          end
          if (aw_fin_s && w_fin_s) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b1;
            state_r   <= RESP;
          end
        end
        RESP: begin
          if (b_hs_s) begin
            bready_r    <= 1'b0;
            done_r      <= 1'b1;
            bus_err_r   <= (bresp != 2'b00);
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          stall_r     <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign unused_s  = ^bid;

  assign req_ready = req_ready_r;
  assign stall_req = stall_r;
  assign done      = done_r;
  assign bus_err   = bus_err_r;
  assign addr_err  = addr_err_r;
  assign awid      = AXI_ID;
  assign awaddr    = awaddr_r;
  assign awlen     = 4'd0;
  assign awsize    = awsize_r;
  assign awburst   = 2'b01;
  assign awvalid   = awvalid_r;
  assign wid       = AXI_ID;
  assign wdata     = wdata_r;
  assign wstrb     = wstrb_r;
  assign wlast     = 1'b1;
  assign wvalid    = wvalid_r;
  assign bready    = bready_r;

endmodule

// File: tb/tb_store_axi_writer.sv
// Directed bench for store_axi_writer: a vector table of single stores with
// the AXI slave always ready, plus sequences for stalls, ordering and reset.
module tb_store_axi_writer;

  localparam logic [2:0] OP_SB = 3'b100;
  localparam logic [2:0] OP_SH = 3'b010;
  localparam logic [2:0] OP_SW = 3'b001;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_ready, stall_req, done, bus_err, addr_err;
  logic [3:0]  awid, awlen, wid, wstrb, bid;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_cmp = 0;
  int n_bad = 0;

  store_axi_writer #(.AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .stall_req(stall_req), .done(done), .bus_err(bus_err),
    .addr_err(addr_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // kind: 0 = full transaction, 1 = misaligned (addr_err), 2 = ignored (op 0)
  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  bresp;
    int          kind;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  size;
    logic        berr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_data  = d;
    step();
    req_valid = 1'b0;
    req_op    = 3'b000;
  endtask

  // Slave is assumed always ready: AW+W at cycle 1, B at cycle 2, done at cycle 3.
  task automatic apply(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    bresp = v.bresp;
    accept(v.op, v.addr, v.data);
    if (v.kind == 0) begin
      chk({t, ".awvalid1"}, awvalid, 1);
      chk({t, ".wvalid1"}, wvalid, 1);
      chk({t, ".awaddr"}, awaddr, v.addr);
      chk({t, ".awsize"}, awsize, v.size);
      chk({t, ".wdata"}, wdata, v.wdata);
      chk({t, ".wstrb"}, wstrb, v.wstrb);
      chk({t, ".stall1"}, stall_req, 1);
      chk({t, ".ready1"}, req_ready, 0);
      step();
      chk({t, ".awvalid2"}, awvalid, 0);
      chk({t, ".bready2"}, bready, 1);
      chk({t, ".done2"}, done, 0);
      chk({t, ".stall2"}, stall_req, 1);
      step();
      chk({t, ".done3"}, done, 1);
      chk({t, ".buserr3"}, bus_err, v.berr);
      chk({t, ".stall3"}, stall_req, 1);
      chk({t, ".bready3"}, bready, 0);
      step();
      chk({t, ".done4"}, done, 0);
      chk({t, ".buserr4"}, bus_err, 0);
      chk({t, ".stall4"}, stall_req, 0);
      chk({t, ".ready4"}, req_ready, 1);
    end else begin
      chk({t, ".addr_err1"}, addr_err, (v.kind == 1) ? 1 : 0);
      chk({t, ".awvalid1"}, awvalid, 0);
      chk({t, ".wvalid1"}, wvalid, 0);
      chk({t, ".stall1"}, stall_req, 0);
      chk({t, ".ready1"}, req_ready, 1);
      step();
      chk({t, ".addr_err2"}, addr_err, 0);
      chk({t, ".awvalid2"}, awvalid, 0);
      chk({t, ".stall2"}, stall_req, 0);
    end
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{OP_SB, 32'h1000_0003, 32'h1234_56AB, 2'b00, 0, 32'hABAB_ABAB, 4'b1000, 3'd0, 1'b0};
    vecs[1]  = '{OP_SH, 32'h0000_2002, 32'hFFFF_BEEF, 2'b00, 0, 32'hBEEF_BEEF, 4'b1100, 3'd1, 1'b0};
    vecs[2]  = '{OP_SW, 32'h0000_2004, 32'hCAFE_F00D, 2'b00, 0, 32'hCAFE_F00D, 4'b1111, 3'd2, 1'b0};
    vecs[3]  = '{OP_SB, 32'h0000_0001, 32'h0000_0055, 2'b00, 0, 32'h5555_5555, 4'b0010, 3'd0, 1'b0};
    vecs[4]  = '{OP_SH, 32'h0000_0000, 32'h1234_5678, 2'b10, 0, 32'h5678_5678, 4'b0011, 3'd1, 1'b1};
    vecs[5]  = '{OP_SW, 32'h0000_3002, 32'h1111_2222, 2'b00, 1, 32'h0, 4'b0, 3'd0, 1'b0};
    vecs[6]  = '{OP_SH, 32'h0000_3001, 32'h3333_4444, 2'b00, 1, 32'h0, 4'b0, 3'd0, 1'b0};
    vecs[7]  = '{3'b011, 32'h0000_4000, 32'h89AB_CDEF, 2'b00, 0, 32'h89AB_CDEF, 4'b1111, 3'd2, 1'b0};
    vecs[8]  = '{3'b110, 32'h0000_4003, 32'h0000_0000, 2'b00, 1, 32'h0, 4'b0, 3'd0, 1'b0};
    vecs[9]  = '{3'b000, 32'h0000_5000, 32'hDEAD_BEEF, 2'b00, 2, 32'h0, 4'b0, 3'd0, 1'b0};
    vecs[10] = '{OP_SB, 32'h0000_0002, 32'h0000_00C3, 2'b11, 0, 32'hC3C3_C3C3, 4'b0100, 3'd0, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_op = 3'b000; req_addr = 32'd0; req_data = 32'd0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00; bid = 4'd1;
    step(); step();
    chk("rst.awvalid", awvalid, 0);
    chk("rst.wvalid", wvalid, 0);
    chk("rst.bready", bready, 0);
    chk("rst.done", done, 0);
    chk("rst.addr_err", addr_err, 0);
    chk("rst.stall", stall_req, 0);
    chk("rst.ready", req_ready, 1);
    chk("rst.awaddr", awaddr, 0);
    chk("rst.wstrb", wstrb, 0);
    chk("rst.awsize", awsize, 0);
    rst = 1'b0;
    chk("const.awid", awid, 4'd1);
    chk("const.awlen", awlen, 0);
    chk("const.awburst", awburst, 2'b01);
    chk("const.wlast", wlast, 1);
    step();

    bvalid = 1'b1;
    for (int i = 0; i < 11; i++) apply(vecs[i], i);

    // AW accepted at once, W held off until cycle 5; early bvalid must be ignored.
    bvalid = 1'b0; bresp = 2'b00; wready = 1'b0; awready = 1'b1;
    accept(OP_SW, 32'h0000_5000, 32'h1122_3344);
    chk("wd.awvalid1", awvalid, 1);
    chk("wd.wvalid1", wvalid, 1);
    step();
    chk("wd.awvalid2", awvalid, 0);
    chk("wd.wvalid2", wvalid, 1);
    bvalid = 1'b1;
    for (int c = 2; c < 5; c++) begin
      if (c > 2) step();
      chk($sformatf("wd.wvalid%0d", c), wvalid, 1);
      chk($sformatf("wd.wdata%0d", c), wdata, 32'h1122_3344);
      chk($sformatf("wd.bready%0d", c), bready, 0);
      chk($sformatf("wd.done%0d", c), done, 0);
    end
    step();
    chk("wd.wvalid5", wvalid, 1);
    chk("wd.bready5", bready, 0);
    wready = 1'b1;
    step();
    chk("wd.wvalid6", wvalid, 0);
    chk("wd.bready6", bready, 1);
    step();
    chk("wd.done7", done, 1);
    chk("wd.buserr7", bus_err, 0);
    chk("wd.stall7", stall_req, 1);
    bvalid = 1'b0;
    step();
    chk("wd.done8", done, 0);
    chk("wd.ready8", req_ready, 1);

    // W completes first, AW one cycle later.
    awready = 1'b0; wready = 1'b1;
    accept(OP_SH, 32'h0000_6002, 32'h0000_A1B2);
    chk("wf.wvalid1", wvalid, 1);
    step();
    chk("wf.wvalid2", wvalid, 0);
    chk("wf.awvalid2", awvalid, 1);
    chk("wf.awaddr2", awaddr, 32'h0000_6002);
    chk("wf.bready2", bready, 0);
    awready = 1'b1;
    step();
    chk("wf.awvalid3", awvalid, 0);
    chk("wf.bready3", bready, 1);
    bvalid = 1'b1;
    step();
    chk("wf.done4", done, 1);
    bvalid = 1'b0;
    step();

    // Reset while stuck in SEND, then a fresh store goes through normally.
    awready = 1'b0; wready = 1'b0;
    accept(OP_SB, 32'h0000_7001, 32'h0000_005A);
    chk("rs.awvalid1", awvalid, 1);
    rst = 1'b1;
    step();
    chk("rs.awvalid2", awvalid, 0);
    chk("rs.wvalid2", wvalid, 0);
    chk("rs.bready2", bready, 0);
    chk("rs.ready2", req_ready, 1);
    chk("rs.stall2", stall_req, 0);
    rst = 1'b0; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    apply('{OP_SB, 32'h0000_7002, 32'h0000_00A5, 2'b00, 0, 32'hA5A5_A5A5, 4'b0100, 3'd0, 1'b0}, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
